// File: rtl/disp_window_gen_if.sv
// Pixel-in, line-buffer SRAM and window-out signals of the 3x3 window generator.
// slave is the generator's view; master is the view of whoever feeds it and owns the SRAM.
interface disp_window_gen_if #(
   parameter int AWIDTH = 11,
   parameter int YWIDTH = 11,
   parameter int DW     = 8
);
   logic              pix_valid;
   logic              pix_sof;
   logic [DW-1:0]     pix_data;
   logic [AWIDTH-1:0] sram_aa;
   logic [3*DW-1:0]   sram_da;
   logic [3*DW-1:0]   sram_bweba;
   logic              sram_weba;
   logic [AWIDTH-1:0] sram_ab;
   logic              sram_webb;
   logic [3*DW-1:0]   sram_qb;
   logic              win_valid;
   logic [9*DW-1:0]   win;
   logic [AWIDTH-1:0] win_x;
   logic [YWIDTH-1:0] win_y;
   logic              frame_done;

   modport slave (
      input  pix_valid, pix_sof, pix_data, sram_qb,
      output sram_aa, sram_da, sram_bweba, sram_weba, sram_ab, sram_webb,
      output win_valid, win, win_x, win_y, frame_done
   );

   modport master (
      output pix_valid, pix_sof, pix_data, sram_qb,
      input  sram_aa, sram_da, sram_bweba, sram_weba, sram_ab, sram_webb,
      input  win_valid, win, win_x, win_y, frame_done
   );
endinterface

// File: rtl/disp_window_gen.sv
// Streaming 3x3 disparity window generator: keeps the two previous rows in a dual-port
// line-buffer SRAM and emits one registered window per input pixel, two cycles later.
module disp_window_gen #(
   parameter int IMG_W  = 1920,
   parameter int IMG_H  = 1080,
   parameter int AWIDTH = 11,
   parameter int YWIDTH = 11,
   parameter int DW     = 8
) (
   input  logic               clk,
   input  logic               rst,
   disp_window_gen_if.slave   bus
);
   localparam logic [AWIDTH-1:0] LP_X_LAST = AWIDTH'(IMG_W - 1);
   localparam logic [YWIDTH-1:0] LP_Y_LAST = YWIDTH'(IMG_H - 1);
   localparam logic [AWIDTH-1:0] LP_X_ONE  = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] LP_X_TWO  = AWIDTH'(2);
   localparam logic [YWIDTH-1:0] LP_Y_ONE  = YWIDTH'(1);
   localparam logic [YWIDTH-1:0] LP_Y_TWO  = YWIDTH'(2);

   logic [AWIDTH-1:0] r_x;
   logic [YWIDTH-1:0] r_y;
   logic              w_restart;
   logic [AWIDTH-1:0] w_pos_x;
   logic [YWIDTH-1:0] w_pos_y;

   logic              r_v1;
   logic [DW-1:0]     r_p1;
   logic [AWIDTH-1:0] r_x1;
   logic [YWIDTH-1:0] r_y1;

   logic [DW-1:0]     w_row_m1;
   logic [DW-1:0]     w_row_m2;
   logic              w_qb_unused;
   logic [3*DW-1:0]   w_col;
   logic [3*DW-1:0]   w_wr_data;
   logic [3*DW-1:0]   r_da_last;

   logic [3*DW-1:0]   r_col0;
   logic [3*DW-1:0]   r_col1;
   logic [3*DW-1:0]   r_col2;
   logic              w_win_ok;
   logic              w_win_last;
   logic              r_win_valid;
   logic [AWIDTH-1:0] r_win_x;
   logic [YWIDTH-1:0] r_win_y;
   logic              r_frame_done;
   logic [9*DW-1:0]   w_win;

   // r_x/r_y point at the next pixel; a qualified sof overrides them to (0,0)
   assign w_restart = bus.pix_valid & bus.pix_sof;
   assign w_pos_x   = w_restart ? '0 : r_x;
   assign w_pos_y   = w_restart ? '0 : r_y;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (bus.pix_valid) begin
         if (w_pos_x == LP_X_LAST) begin
            r_x <= '0;
            r_y <= w_pos_y + LP_Y_ONE;
         end else begin
            r_x <= w_pos_x + LP_X_ONE;
            r_y <= w_pos_y;
         end
      end
   end

   assign bus.sram_ab    = w_pos_x;
   assign bus.sram_webb  = 1'b1;
   assign bus.sram_bweba = '1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1 <= 1'b0;
         r_p1 <= '0;
         r_x1 <= '0;
         r_y1 <= '0;
      end else begin
         r_v1 <= bus.pix_valid;
         if (bus.pix_valid) begin
            r_p1 <= bus.pix_data;
            r_x1 <= w_pos_x;
            r_y1 <= w_pos_y;
         end
      end
   end

   assign w_row_m1    = bus.sram_qb[DW-1:0];
   assign w_row_m2    = bus.sram_qb[2*DW-1:DW];
   assign w_qb_unused = ^bus.sram_qb[3*DW-1:2*DW];

   // column word keeps row r (0 = oldest) at [DW*r +: DW]
   assign w_col     = {r_p1, w_row_m1, w_row_m2};
   assign w_wr_data = {{DW{1'b0}}, w_row_m1, r_p1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_da_last <= '0;
      end else if (r_v1) begin
         r_da_last <= w_wr_data;
      end
   end

   // write-back ages the column by one row; idle cycles keep the last address and data
   assign bus.sram_weba = ~r_v1;
   assign bus.sram_aa   = r_x1;
   assign bus.sram_da   = r_v1 ? w_wr_data : r_da_last;

   assign w_win_ok   = r_v1 && (r_x1 >= LP_X_TWO) && (r_y1 >= LP_Y_TWO);
   assign w_win_last = (r_x1 == LP_X_LAST) && (r_y1 == LP_Y_LAST);

   // columns are not cleared at a row wrap; the x >= 2 gate hides stale ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col0       <= '0;
         r_col1       <= '0;
         r_col2       <= '0;
         r_win_valid  <= 1'b0;
         r_win_x      <= '0;
         r_win_y      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_valid  <= w_win_ok;
         r_frame_done <= w_win_ok && w_win_last;
         if (r_v1) begin
            r_col0 <= r_col1;
            r_col1 <= r_col2;
            r_col2 <= w_col;
         end
         if (w_win_ok) begin
            r_win_x <= r_x1 - LP_X_ONE;
            r_win_y <= r_y1 - LP_Y_ONE;
         end
      end
   end

   always_comb begin
      w_win = '0;
      for (int r = 0; r < 3; r++) begin
         w_win[DW*(3*r+0) +: DW] = r_col0[DW*r +: DW];
         w_win[DW*(3*r+1) +: DW] = r_col1[DW*r +: DW];
         w_win[DW*(3*r+2) +: DW] = r_col2[DW*r +: DW];
      end
   end

   assign bus.win_valid  = r_win_valid;
   assign bus.win        = w_win;
   assign bus.win_x      = r_win_x;
   assign bus.win_y      = r_win_y;
   assign bus.frame_done = r_frame_done;
endmodule
